sp_ram_banked_xbar: RTL and testbench

//  Multi-port, word-interleaved, banked scratchpad built from NUM_BANKS single-port RAM banks.
//  Up to NUM_PORTS masters (core instr/data, debug, DMA) issue req/gnt/rvalid transactions.

---
 rtl/sp_ram_banked_xbar.sv | 160 ++++++++++++++++
 tb/tb_sp_ram_banked_xbar.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_banked_xbar.sv
// Word-interleaved banked scratchpad: NUM_BANKS single-port banks shared by NUM_PORTS masters,
// each bank with its own round-robin arbiter and a 1 (or 2 with OUT_REG) cycle response pipe.
module sp_ram_banked_xbar #(
   parameter int unsigned RAM_SIZE   = 32768,
   parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned OUT_REG    = 0
) (
   input  logic                              clk,
   input  logic                              rstn_i,
   input  logic [NUM_PORTS-1:0]              req_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_PORTS-1:0]              we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_PORTS-1:0]              gnt_o,
   output logic [NUM_PORTS-1:0]              rvalid_o,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o
);
   localparam int unsigned NBE   = DATA_WIDTH / 8;
   localparam int unsigned OFS   = $clog2(NBE);
   localparam int unsigned BB    = $clog2(NUM_BANKS);
   localparam int unsigned BW    = (BB == 0) ? 1 : BB;
   localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned RW    = ADDR_WIDTH - OFS - BB;
   localparam int unsigned DEPTH = 2 ** RW;

   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH == 0) begin : g_bad_dw
      $error("DATA_WIDTH must be a non-zero multiple of 8");
   end
   if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_np
      $error("NUM_PORTS must be 1..8");
   end
   if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_nb
      $error("NUM_BANKS must be a power of two");
   end
   if (RAM_SIZE != NBE * NUM_BANKS * DEPTH) begin : g_bad_size
      $error("RAM_SIZE must be DATA_WIDTH/8*NUM_BANKS*2^k with ADDR_WIDTH=$clog2(RAM_SIZE)");
   end

   logic [BW-1:0]         w_bank       [NUM_PORTS];
   logic [RW-1:0]         w_row        [NUM_PORTS];
   logic [NBE-1:0]        w_be         [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_wdata      [NUM_PORTS];
   logic [NUM_BANKS-1:0]  w_bank_gnt;
   logic [PW-1:0]         w_sel_port   [NUM_BANKS];
   logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
   logic [NUM_PORTS-1:0]  w_gnt;
   logic [PW-1:0]         r_ptr        [NUM_BANKS];
   logic [NUM_PORTS-1:0]  r_vld1;
   logic [BW-1:0]         r_bsel1      [NUM_PORTS];

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_bank[p]  = BW'((addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] >> OFS) & (NUM_BANKS - 1));
         w_row[p]   = RW'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] >> (OFS + BB));
         w_be[p]    = be_i[p*NBE +: NBE];
         w_wdata[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Per-bank round robin: first requester at or after the pointer wins; reset blocks all grants.
   always_comb begin
      int idx;
      idx        = 0;
      w_bank_gnt = '0;
      w_gnt      = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_sel_port[b] = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(r_ptr[b]) + k;
            if (idx >= int'(NUM_PORTS)) idx = idx - int'(NUM_PORTS);
            if (rstn_i && !w_bank_gnt[b] && req_i[idx] && (w_bank[idx] == BW'(b))) begin
               w_bank_gnt[b] = 1'b1;
               w_sel_port[b] = PW'(idx);
            end
         end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_gnt[p] = w_bank_gnt[w_bank[p]] && (w_sel_port[w_bank[p]] == PW'(p));
      end
   end

   assign gnt_o = w_gnt;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [DATA_WIDTH-1:0] r_rdata;
      logic [RW-1:0]         w_brow;
      logic                  w_bwe;
      logic [NBE-1:0]        w_bbe;
      logic [DATA_WIDTH-1:0] w_bwdata;

      assign w_brow   = w_row[w_sel_port[b]];
      assign w_bwe    = we_i[w_sel_port[b]];
      assign w_bbe    = w_be[w_sel_port[b]];
      assign w_bwdata = w_wdata[w_sel_port[b]];

      // Read returns pre-write content; output register holds while the bank is idle.
      always_ff @(posedge clk) begin
         if (w_bank_gnt[b]) begin
            if (w_bwe) begin
               for (int i = 0; i < NBE; i++) begin
                  if (w_bbe[i]) r_mem[w_brow][i*8 +: 8] <= w_bwdata[i*8 +: 8];
               end
            end
            r_rdata <= r_mem[w_brow];
         end
      end

      assign w_bank_rdata[b] = r_rdata;
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
         for (int p = 0; p < NUM_PORTS; p++) r_bsel1[p] <= '0;
         r_vld1 <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bank_gnt[b]) begin
               r_ptr[b] <= (w_sel_port[b] == PW'(NUM_PORTS - 1)) ? '0 : w_sel_port[b] + 1'b1;
            end
         end
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) r_bsel1[p] <= w_bank[p];
         end
         r_vld1 <= w_gnt;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic [NUM_PORTS-1:0]  r_vld2;
      logic [DATA_WIDTH-1:0] r_rdata2 [NUM_PORTS];

      always_ff @(posedge clk or negedge rstn_i) begin
         if (!rstn_i) r_vld2 <= '0;
         else         r_vld2 <= r_vld1;
      end

      always_ff @(posedge clk) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_vld1[p]) r_rdata2[p] <= w_bank_rdata[r_bsel1[p]];
         end
      end

      assign rvalid_o = r_vld2;
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
         assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata2[p];
      end
   end else begin : g_noreg
      assign rvalid_o = r_vld1;
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
         assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = w_bank_rdata[r_bsel1[p]];
      end
   end

endmodule

// File: tb/tb_sp_ram_banked_xbar.sv
// Directed plus randomized bench for sp_ram_banked_xbar, checked against a word-array model
// with per-bank round-robin pointers and a due-cycle response list.
module tb_sp_ram_banked_xbar;
   localparam int NP  = 2;
   localparam int NB  = 4;
   localparam int AW  = 15;
   localparam int DW  = 32;
   localparam int OR  = 0;
   localparam int LAT = 1 + OR;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NP-1:0]     req;
   logic [NP*AW-1:0]  addr;
   logic [NP-1:0]     we;
   logic [NP*4-1:0]   be;
   logic [NP*DW-1:0]  wdata;
   logic [NP-1:0]     gnt_o;
   logic [NP-1:0]     rvalid_o;
   logic [NP*DW-1:0]  rdata_o;

   sp_ram_banked_xbar #(
      .RAM_SIZE(32768), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .NUM_PORTS(NP), .NUM_BANKS(NB), .OUT_REG(OR)
   ) dut (
      .clk(clk), .rstn_i(rstn), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
      .wdata_i(wdata), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      int          due;
      bit          rd;
      logic [31:0] data;
   } resp_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   resp_t       rq[$];
   logic [31:0] mem[int];
   int          ptr[NB];
   logic [NP-1:0] model_gnt;
   logic [NP-1:0] last_gnt;
   int          g_cyc[NP];
   int          got_n[NP];
   int          got_cyc[NP][64];
   logic [31:0] got_dat[NP][64];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int word_of(input int p);
      logic [AW-1:0] a;
      a = addr[p*AW +: AW];
      return int'(a) / 4;
   endfunction

   task automatic set_port(input int p, input bit r, input int a, input bit w,
                           input logic [3:0] b, input logic [31:0] d);
      req[p]           = r;
      addr[p*AW +: AW] = AW'(a);
      we[p]            = w;
      be[p*4 +: 4]     = b;
      wdata[p*DW +: DW] = d;
   endtask

   task automatic model_reset();
      rq.delete();
      for (int b = 0; b < NB; b++) ptr[b] = 0;
   endtask

   task automatic step(input bit rst_mid = 1'b0);
      logic [NP-1:0] eg;
      int            q;
      int            found;
      resp_t         r;
      logic [31:0]   cur;
      @(negedge clk);
      eg = '0;
      if (rstn) begin
         for (int b = 0; b < NB; b++) begin
            bit done;
            done = 1'b0;
            for (int k = 0; k < NP; k++) begin
               q = (ptr[b] + k) % NP;
               if (!done && req[q] && (word_of(q) % NB == b)) begin
                  eg[q] = 1'b1;
                  done  = 1'b1;
               end
            end
         end
      end
      chk("gnt", gnt_o, eg);
      last_gnt = gnt_o;
      for (int p = 0; p < NP; p++) begin
         found = -1;
         for (int i = 0; i < rq.size(); i++) begin
            if (rq[i].port == p && rq[i].due == cyc) found = i;
         end
         chk("rvalid", rvalid_o[p], found >= 0);
         if (found >= 0) begin
            if (rq[found].rd) chk("rdata", rdata_o[p*DW +: DW], rq[found].data);
            if (got_n[p] < 64) begin
               got_cyc[p][got_n[p]] = cyc;
               got_dat[p][got_n[p]] = rdata_o[p*DW +: DW];
               got_n[p]++;
            end
            rq.delete(found);
         end
      end
      // All reads see memory as it was before this cycle's writes.
      for (int p = 0; p < NP; p++) begin
         if (eg[p]) begin
            r.port = p;
            r.due  = cyc + LAT;
            r.rd   = !we[p];
            r.data = mem.exists(word_of(p)) ? mem[word_of(p)] : 'x;
            rq.push_back(r);
            g_cyc[p] = cyc;
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (eg[p] && we[p]) begin
            cur = mem.exists(word_of(p)) ? mem[word_of(p)] : 32'h0;
            for (int i = 0; i < 4; i++) begin
               if (be[p*4 + i]) cur[i*8 +: 8] = wdata[p*DW + i*8 +: 8];
            end
            mem[word_of(p)] = cur;
            ptr[word_of(p) % NB] = (p + 1) % NP;
         end else if (eg[p]) begin
            ptr[word_of(p) % NB] = (p + 1) % NP;
         end
      end
      model_gnt = eg;
      if (rst_mid) begin
         #1;
         rstn = 1'b0;
         model_reset();
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic xact(input int p, input int a, input bit w, input logic [3:0] b,
                       input logic [31:0] d);
      bit g;
      g = 1'b0;
      set_port(p, 1'b1, a, w, b, d);
      for (int n = 0; n < 20 && !g; n++) begin
         step();
         g = model_gnt[p];
      end
      chk("xact_grant_timeout", g, 1'b1);
      set_port(p, 1'b0, 0, 1'b0, 4'h0, 32'h0);
   endtask

   initial begin
      int          b0;
      int          b1;
      int          t;
      logic [NP-1:0] g4[4];
      bit          pend[NP];

      for (int p = 0; p < NP; p++) got_n[p] = 0;
      model_reset();
      rstn = 1'b0;
      req = '0; addr = '0; we = '0; be = '0; wdata = '0;

      // 1: reset with all requests high, then grants on release.
      set_port(0, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0000_0000);
      set_port(1, 1'b1, 32'h4, 1'b1, 4'hF, 32'h0000_0004);
      #3;
      chk("t1_gnt_in_reset", gnt_o, 2'b00);
      chk("t1_rvalid_in_reset", rvalid_o, 2'b00);
      step();
      rstn = 1'b1;
      step();
      chk("t1_gnt_after_release", last_gnt, 2'b11);
      req = '0;
      drain(LAT + 1);

      for (int w = 2; w < 32; w++) xact(w % NP, w * 4, 1'b1, 4'hF, $urandom);

      // 2: byte-enable merge and read latency.
      xact(0, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
      xact(0, 32'h10, 1'b1, 4'h1, 32'h0000_00AA);
      drain(LAT + 1);
      b0 = got_n[0];
      xact(0, 32'h10, 1'b0, 4'hF, 32'h0);
      t = g_cyc[0];
      drain(LAT + 1);
      chk("t2_resp_count", got_n[0] - b0, 1);
      chk("t2_rdata", got_dat[0][b0], 32'hDEAD_BEAA);
      chk("t2_latency", got_cyc[0][b0] - t, LAT);

      // 3: different banks proceed in parallel.
      b0 = got_n[0]; b1 = got_n[1];
      set_port(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
      set_port(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
      step();
      chk("t3_both_gnt", last_gnt, 2'b11);
      req = '0;
      drain(LAT + 1);
      chk("t3_p0_resp", got_n[0] - b0, 1);
      chk("t3_p1_resp", got_n[1] - b1, 1);
      chk("t3_same_cycle", got_cyc[0][b0] - got_cyc[1][b1], 0);

      xact(0, 32'h20, 1'b1, 4'hF, 32'hCAFE_F00D);
      drain(LAT + 1);
      rstn = 1'b0;
      model_reset();
      drain(2);
      rstn = 1'b1;

      // 4: contention on bank 0 alternates from pointer 0.
      b0 = got_n[0]; b1 = got_n[1];
      set_port(0, 1'b1, 32'h00, 1'b0, 4'hF, 32'h0);
      set_port(1, 1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         g4[k] = last_gnt;
      end
      req = '0;
      drain(LAT + 1);
      for (int k = 0; k < 4; k++) chk("t4_alternate", g4[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t4_p0_count", got_n[0] - b0, 2);
      chk("t4_p1_count", got_n[1] - b1, 2);

      // 5: same-row read/write serialised by the arbiter.
      b0 = got_n[0];
      set_port(0, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
      set_port(1, 1'b1, 32'h20, 1'b1, 4'hF, 32'h1234_5678);
      step();
      chk("t5_read_first", last_gnt, 2'b01);
      set_port(0, 1'b0, 0, 1'b0, 4'h0, 32'h0);
      step();
      chk("t5_write_second", last_gnt, 2'b10);
      set_port(1, 1'b0, 0, 1'b0, 4'h0, 32'h0);
      xact(0, 32'h20, 1'b0, 4'hF, 32'h0);
      drain(LAT + 1);
      chk("t5_old_data", got_dat[0][b0], 32'hCAFE_F00D);
      chk("t5_new_data", got_dat[0][b0 + 1], 32'h1234_5678);

      // 6: reset between grant and response drops the response; memory persists.
      xact(0, 32'h30, 1'b1, 4'hF, 32'h55AA_55AA);
      drain(LAT + 1);
      b0 = got_n[0];
      set_port(0, 1'b1, 32'h30, 1'b0, 4'hF, 32'h0);
      step(1'b1);
      chk("t6_gnt_before_reset", last_gnt, 2'b01);
      req = '0;
      chk("t6_rvalid_in_reset", rvalid_o, 2'b00);
      drain(3);
      chk("t6_no_response", got_n[0] - b0, 0);
      rstn = 1'b1;
      xact(0, 32'h30, 1'b0, 4'hF, 32'h0);
      drain(LAT + 1);
      chk("t6_persist", got_dat[0][b0], 32'h55AA_55AA);

      // Randomized traffic over the initialised 32-word window.
      for (int p = 0; p < NP; p++) pend[p] = 1'b0;
      for (int n = 0; n < 600; n++) begin
         for (int p = 0; p < NP; p++) begin
            if (!pend[p]) begin
               if ($urandom_range(0, 3) != 0) begin
                  set_port(p, 1'b1, $urandom_range(0, 31) * 4 + $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), 4'($urandom), $urandom);
                  pend[p] = 1'b1;
               end else begin
                  set_port(p, 1'b0, 0, 1'b0, 4'h0, 32'h0);
               end
            end
         end
         step();
         for (int p = 0; p < NP; p++) if (model_gnt[p]) pend[p] = 1'b0;
      end
      req = '0;
      drain(LAT + 2);
      chk("drain_empty", rq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
